// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//
// Shared definitions for the 2x2 fixed-point systolic array and its result
// drain.
//
// Contents:
//   SIZE_DEFAULT / DECIMAL_DEFAULT : element width and fractional bits
//   drain_state_t                  : result-drain FSM states
//   ROW_TO_SLOT                    : row-major element index -> bus slot map
//   bus_slot()                     : helper that reads ROW_TO_SLOT
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int SIZE_DEFAULT    = 8;
    localparam int DECIMAL_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } drain_state_t;

    // The array's result bus is column-major (c11, c21, c12, c22).
    // Consumers want row-major (c11, c12, c21, c22).
    // Entry r (2 bits at [2r+1:2r]) holds the bus slot of row-major element r.
    // The table is {0,2,1,3}, packed LSB-first.
    localparam logic [7:0] ROW_TO_SLOT = {2'd3, 2'd1, 2'd2, 2'd0};

    function automatic logic [1:0] bus_slot(input logic [1:0] row_idx);
        return ROW_TO_SLOT[int'(row_idx) * 2 +: 2];
    endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// ---------------------------------------------------------------------------
// systolic_result_drain_if
//
// Element stream leaving the systolic result drain. It uses a valid/ready
// handshake with one element per beat.
//
// Signals:
//   dout       : current element (SIZE bits, signed fixed point)
//   dout_idx   : row-major index of dout (0=c11, 1=c12, 2=c21, 3=c22)
//   dout_valid : dout/dout_idx/dout_last are valid
//   dout_ready : consumer accepts the beat when high together with dout_valid
//   dout_last  : marks the beat at index 3
//
// Modports:
//   master : the drain (drives the data, samples ready)
//   slave  : the consumer (samples the data, drives ready)
// ---------------------------------------------------------------------------
interface systolic_result_drain_if
    import systolic_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
);

    logic [SIZE-1:0] dout;
    logic [1:0]      dout_idx;
    logic            dout_valid;
    logic            dout_ready;
    logic            dout_last;

    modport master (
        output dout,
        output dout_idx,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_idx,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );

endinterface

// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Output-side companion to the 2x2 systolic array. On an accepted start it
// counts LATENCY cycles. It then captures the packed result bus and streams
// the four elements out in row-major order, one per beat, over a valid/ready
// handshake.
//
// Parameters:
//   SIZE    : element width in bits (signed two's complement fixed point)
//   DECIMAL : fractional bits. They are carried only; values are never rescaled.
//   LATENCY : cycles from an accepted start to a stable mi. Legal range 1..255.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   start : one-cycle pulse that starts a drain. It is honoured only in IDLE
//           and DONE.
//   mi    : array result bus, column-major
//           [S-1:0]=c11 [2S-1:S]=c21 [3S-1:2S]=c12 [4S-1:3S]=c22
//   out   : element stream (systolic_result_drain_if master)
//   busy  : high while waiting for the result or streaming it
//   done  : one-cycle pulse after the final beat has been accepted
//
// Build option:
//   SYSTOLIC_DRAIN_RELU_EN : when defined, negative elements (MSB set) are
//                            stored as zero at capture. Otherwise elements
//                            pass through bit-exact.
//
// Every output is a flop. dout_ready only steers next-state logic, so no
// combinational path runs from ready to any output.
// ---------------------------------------------------------------------------
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int SIZE    = SIZE_DEFAULT,
    parameter int DECIMAL = DECIMAL_DEFAULT,
    parameter int LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*SIZE-1:0]     mi,
    systolic_result_drain_if.master out,
    output logic                  busy,
    output logic                  done
);

    // Out-of-range parameters land in these named, empty scopes. They are
    // visible in the elaborated hierarchy, and the values stay referenced.
    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_out_of_range
    end
    if (DECIMAL < 0 || DECIMAL >= SIZE) begin : g_decimal_out_of_range
    end

    // The counter runs 0..LATENCY-1. Capture happens on the edge where it
    // reads LATENCY-1, which is exactly LATENCY edges after start was sampled.
    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    drain_state_t    state_reg;
    logic [7:0]      cnt_reg;
    logic [1:0]      idx_reg;
    logic [1:0]      idx_next;
    logic [SIZE-1:0] elem_buf [4];

    // -----------------------------------------------------------------------
    // Capture path: reorder the column-major bus into row-major elements and
    // optionally clamp negative values to zero.
    // -----------------------------------------------------------------------
    logic [SIZE-1:0] cap_elem [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_cap
        localparam int SLOT = int'(bus_slot(2'(gi)));

        logic [SIZE-1:0] raw_elem;
        assign raw_elem = mi[SLOT*SIZE +: SIZE];

`ifdef SYSTOLIC_DRAIN_RELU_EN
        assign cap_elem[gi] = raw_elem[SIZE-1] ? '0 : raw_elem;
`else
        assign cap_elem[gi] = raw_elem;
`endif
    end

    assign idx_next = idx_reg + 2'd1;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            for (int i = 0; i < 4; i++) begin
                elem_buf[i] <= '0;
            end
            out.dout       <= '0;
            out.dout_idx   <= '0;
            out.dout_valid <= 1'b0;
            out.dout_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                    end
                end

                WAIT: begin
                    if (cnt_reg == LAST_CNT) begin
                        // mi is sampled on this edge only. Later bus activity
                        // cannot disturb the elements being streamed.
                        for (int i = 0; i < 4; i++) begin
                            elem_buf[i] <= cap_elem[i];
                        end
                        idx_reg        <= '0;
                        // The first beat goes straight from the capture mux.
                        // This lets dout_valid rise on the capture edge.
                        out.dout       <= cap_elem[0];
                        out.dout_idx   <= '0;
                        out.dout_valid <= 1'b1;
                        out.dout_last  <= 1'b0;
                        state_reg      <= SEND;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end

                SEND: begin
                    // dout_valid is always high in SEND, so ready alone
                    // signals acceptance. Without ready nothing changes.
                    if (out.dout_ready) begin
                        if (idx_reg == 2'd3) begin
                            idx_reg        <= '0;
                            out.dout       <= '0;
                            out.dout_idx   <= '0;
                            out.dout_valid <= 1'b0;
                            out.dout_last  <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            idx_reg       <= idx_next;
                            out.dout      <= elem_buf[idx_next];
                            out.dout_idx  <= idx_next;
                            out.dout_last <= (idx_next == 2'd3);
                        end
                    end
                end

                DONE: begin
                    // A start here chains straight into the next drain. This
                    // gives the minimum start-to-start period.
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
